// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Definitions shared by the data-memory responder and its lane aligner:
//   - RV32I load/store funct3 width/sign codes
//   - responder FSM state encoding
//   - latency countdown width (covers LATENCY values 1..15)
//   - helpers that classify a request as illegal or misaligned, and that
//     pull a misaligned byte offset down to natural alignment
// No ports (package only).
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Unsigned forms only make sense for loads; a store has nothing to
    // zero-extend, so BU/HU stores are rejected alongside reserved codes.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: return off[0];
            F3_W:        return (off != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_H, F3_HU: return {off[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return off;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// ---------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for the data-memory responder.
// Loads: selects the byte/halfword/word addressed by byte_off out of the
// stored word and sign- or zero-extends it according to funct3.
// Stores: shifts right-aligned store data onto its byte lanes and produces
// the matching per-byte write enables.
// byte_off is expected to be already naturally aligned for H/HU/W.
// Ports:
//   funct3   in   width/sign code (B, H, W, BU, HU)
//   byte_off in   addr[1:0] of the access
//   rword    in   stored word at the indexed location
//   wdata    in   right-aligned store data
//   rdata    out  extended load result (0 for reserved codes)
//   byte_en  out  byte-lane write enables (0 for reserved codes)
//   wlanes   out  store data shifted onto its lanes
// ---------------------------------------------------------------------------
module dmem_lane_align
    import riscv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         funct3,
    input  logic [1:0]         byte_off,
    input  logic [WIDTH-1:0]   rword,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic [WIDTH/8-1:0] byte_en,
    output logic [WIDTH-1:0]   wlanes
);

    localparam int NB = WIDTH / 8;

    logic [4:0]       shamt;
    logic [WIDTH-1:0] rshift;

    // Shifting the word down by the byte offset puts the addressed lane(s)
    // at bit 0, so every load form just extends from the bottom bits.
    assign shamt  = {byte_off, 3'b000};
    assign rshift = rword >> shamt;

    always_comb begin
        rdata   = '0;
        byte_en = '0;
        wlanes  = wdata << shamt;
        case (funct3)
            F3_B: begin
                rdata   = {{(WIDTH-8){rshift[7]}}, rshift[7:0]};
                byte_en = NB'(1) << byte_off;
            end
            F3_H: begin
                rdata   = {{(WIDTH-16){rshift[15]}}, rshift[15:0]};
                byte_en = NB'(3) << byte_off;
            end
            F3_W: begin
                rdata   = rword;
                byte_en = '1;
            end
            F3_BU: begin
                rdata   = {{(WIDTH-8){1'b0}}, rshift[7:0]};
                byte_en = NB'(1) << byte_off;
            end
            F3_HU: begin
                rdata   = {{(WIDTH-16){1'b0}}, rshift[15:0]};
                byte_en = NB'(3) << byte_off;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder for an RV32I-style core.
// A request is accepted in IDLE, waits LATENCY cycles, then the response is
// held in RESP until the initiator consumes it. Stores are committed once,
// on entry to RESP, writing only the enabled byte lanes.
//
// Build option (macro DMEM_MISALIGN_TRAP_EN):
//   defined   - misaligned H/HU/W accesses fault (rsp_err=1, no write)
//   undefined - misaligned addresses are pulled down to natural alignment
//
// Parameters:
//   WIDTH   data/address width in bits
//   DEPTH   storage depth in WIDTH-bit words (power of two)
//   LATENCY cycles from accept to rsp_valid (1..15)
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE only)
//   req_we     in   1 = store, 0 = load
//   req_funct3 in   width/sign code
//   req_addr   in   byte address (upper bits beyond storage ignored)
//   req_wdata  in   right-aligned store data
//   rsp_valid  out  response available
//   rsp_ready  in   initiator consumes the response
//   rsp_rdata  out  extended load data; 0 for stores and faults
//   rsp_err    out  request faulted
// ---------------------------------------------------------------------------
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int NB = WIDTH / 8;

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

    dmem_state_e          state;
    dmem_state_e          state_next;
    logic [LAT_CNT_W-1:0] cnt;
    logic [LAT_CNT_W-1:0] cnt_next;
    logic                 ready_en;

    logic                 cap_we;
    logic [2:0]           cap_funct3;
    logic [AW+1:0]        cap_addr;
    logic [WIDTH-1:0]     cap_wdata;

    logic                 op_we;
    logic [2:0]           op_funct3;
    logic [AW+1:0]        op_addr;
    logic [WIDTH-1:0]     op_wdata;

    logic                 accept;
    logic                 go_resp;
    logic                 op_err;
    logic                 commit;
    logic [1:0]           eff_off;
    logic [AW-1:0]        idx;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]     load_data;
    logic [WIDTH-1:0]     wlanes;
    logic [NB-1:0]        byte_en;

    logic                 unused_addr_hi;

    // Address bits above the storage index only wrap around.
    assign unused_addr_hi = ^req_addr[WIDTH-1:AW+2];

    // ready_en keeps req_ready low throughout reset and raises it from the
    // first clock edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign req_ready = (state == IDLE) && ready_en;
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    // The operation being resolved: live request fields when LATENCY=1
    // takes IDLE straight to RESP, otherwise the fields captured at accept.
    assign op_we     = (state == IDLE) ? req_we           : cap_we;
    assign op_funct3 = (state == IDLE) ? req_funct3       : cap_funct3;
    assign op_addr   = (state == IDLE) ? req_addr[AW+1:0] : cap_addr;
    assign op_wdata  = (state == IDLE) ? req_wdata        : cap_wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign eff_off = op_addr[1:0];
    assign op_err  = funct3_illegal(op_we, op_funct3)
                   || addr_misaligned(op_funct3, op_addr[1:0]);
`else
    assign eff_off = align_offset(op_funct3, op_addr[1:0]);
    assign op_err  = funct3_illegal(op_we, op_funct3);
`endif

    assign idx    = op_addr[AW+1:2];
    assign commit = go_resp && op_we && !op_err;

    dmem_lane_align #(
        .WIDTH (WIDTH)
    ) u_lane_align (
        .funct3   (op_funct3),
        .byte_off (eff_off),
        .rword    (mem[idx]),
        .wdata    (op_wdata),
        .rdata    (load_data),
        .byte_en  (byte_en),
        .wlanes   (wlanes)
    );

    // State and countdown registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic. In WAIT the countdown is never 0 (LATENCY>=2 there),
    // so stepping from 1 to 0 is the cycle that enters RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        go_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt <= CNT_ONE) begin
                    state_next = RESP;
                    cnt_next   = '0;
                    go_resp    = 1'b1;
                end else begin
                    cnt_next   = cnt - CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Request fields are latched only on accept, so req_valid outside IDLE
    // cannot disturb an in-flight operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_we     <= 1'b0;
            cap_funct3 <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
        end else if (accept) begin
            cap_we     <= req_we;
            cap_funct3 <= req_funct3;
            cap_addr   <= req_addr[AW+1:0];
            cap_wdata  <= req_wdata;
        end
    end

    // Response payload is registered on entry to RESP and held there until
    // the next operation resolves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (go_resp) begin
            rsp_err   <= op_err;
            rsp_rdata <= (op_err || op_we) ? '0 : load_data;
        end
    end

    // Storage is deliberately not reset; a reset only abandons the pending
    // operation because go_resp can never fire while state is held in IDLE.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. A byte-array model of the storage
// predicts every response from the load/store rules; directed scenarios use
// literal expected values.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 3;
    localparam int NBYTES  = DEPTH * 4;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        req_valid  = 1'b0;
    logic        req_ready;
    logic        req_we     = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr   = '0;
    logic [31:0] req_wdata  = '0;
    logic        rsp_valid;
    logic        rsp_ready  = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mref [NBYTES];

    always #5 clk = ~clk;

    dmem_responder #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // Reference model: byte-addressed storage, wrap modulo storage size.
    task automatic model_txn(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] exp_rdata, output logic exp_err);
        int     size;
        int     a;
        bit     sgn;
        bit     legal;
        longint v;
        legal = (f3 == LB) || (f3 == LH) || (f3 == LW) ||
                (!we && ((f3 == LBU) || (f3 == LHU)));
        size  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        sgn   = (f3[2] == 1'b0);
        a     = int'(addr % NBYTES);
        exp_err   = !legal;
        exp_rdata = '0;
        if (legal && (a % size) != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            exp_err = 1'b1;
`else
            a = a - (a % size);
`endif
        end
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mref[a+i] = wdata[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v + (longint'(mref[a+i]) << (8*i));
                if (sgn && size < 4 && v >= (longint'(1) << (8*size-1)))
                    v = v - (longint'(1) << (8*size));
                exp_rdata = v[31:0];
            end
        end
    endtask

    // Drivers (no comparisons apart from the bounded wait for req_ready).
    task automatic start_req(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL req_ready_wait: req_ready=%b, required 1", req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (rsp_valid !== 1'b1 && lat < 50);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        start_req(we, f3, addr, wdata);
        wait_rsp(lat);
        rdata = rsp_rdata;
        err   = rsp_err;
        finish_rsp();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 4;
        if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b, required 0", req_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata: got %h, required 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_err: got %b, required 0", rsp_err); end
        rst = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL release_before_edge: req_ready=%b, required 0", req_ready); end
        @(negedge clk);
        n_checks += 2;
        if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL release_after_edge: req_ready=%b, required 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL release_rsp_valid: got %b, required 0", rsp_valid); end
    endtask

    task automatic test_fill();
        logic [31:0] d, er, gr;
        logic        ee, ge;
        int          lat;
        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            model_txn(1'b1, LW, 32'(w*4), d, er, ee);
            do_txn(1'b1, LW, 32'(w*4), d, gr, ge, lat);
            n_checks++;
            if (ge !== ee) begin n_fail++; $display("[TB] FAIL fill_err w=%0d: got %b, required %b", w, ge, ee); end
        end
    endtask

    task automatic test_word();
        logic [31:0] er, gr;
        logic        ee, ge;
        int          lat;
        model_txn(1'b1, LW, 32'h10, 32'hDEADBEEF, er, ee);
        do_txn(1'b1, LW, 32'h10, 32'hDEADBEEF, gr, ge, lat);
        n_checks += 3;
        if (lat != LATENCY) begin n_fail++; $display("[TB] FAIL sw_latency: got %0d, required %0d", lat, LATENCY); end
        if (ge !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_err: got %b, required 0", ge); end
        if (gr !== 32'h0) begin n_fail++; $display("[TB] FAIL sw_rdata: got %h, required 0", gr); end
        model_txn(1'b0, LW, 32'h10, 32'h0, er, ee);
        do_txn(1'b0, LW, 32'h10, 32'h0, gr, ge, lat);
        n_checks += 2;
        if (lat != LATENCY) begin n_fail++; $display("[TB] FAIL lw_latency: got %0d, required %0d", lat, LATENCY); end
        if (gr !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL lw_rdata: got %h, required deadbeef", gr); end
    endtask

    task automatic test_byte();
        logic [31:0] er, gr;
        logic        ee, ge;
        int          lat;
        model_txn(1'b1, LB, 32'h11, 32'h80, er, ee);
        do_txn(1'b1, LB, 32'h11, 32'h80, gr, ge, lat);
        n_checks++;
        if (ge !== 1'b0) begin n_fail++; $display("[TB] FAIL sb_err: got %b, required 0", ge); end
        do_txn(1'b0, LB, 32'h11, 32'h0, gr, ge, lat);
        n_checks++;
        if (gr !== 32'hFFFFFF80) begin n_fail++; $display("[TB] FAIL lb_sign: got %h, required ffffff80", gr); end
        do_txn(1'b0, LBU, 32'h11, 32'h0, gr, ge, lat);
        n_checks++;
        if (gr !== 32'h00000080) begin n_fail++; $display("[TB] FAIL lbu_zero: got %h, required 00000080", gr); end
        do_txn(1'b0, LW, 32'h10, 32'h0, gr, ge, lat);
        n_checks++;
        if (gr !== 32'hDEAD80EF) begin n_fail++; $display("[TB] FAIL lw_after_sb: got %h, required dead80ef", gr); end
    endtask

    task automatic test_stall();
        logic [31:0] gr;
        logic        ge;
        int          lat;
        start_req(1'b0, LW, 32'h10, 32'h0);
        wait_rsp(lat);
        n_checks += 2;
        if (lat != LATENCY) begin n_fail++; $display("[TB] FAIL stall_latency: got %0d, required %0d", lat, LATENCY); end
        if (rsp_rdata !== 32'hDEAD80EF) begin n_fail++; $display("[TB] FAIL stall_first: got %h, required dead80ef", rsp_rdata); end
        for (int i = 0; i < 5; i++) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = LW;
            req_addr   = 32'h10;
            req_wdata  = 32'h0BADF00D;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
            n_checks += 3;
            if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_valid c%0d: got %b, required 1", i, rsp_valid); end
            if (rsp_rdata !== 32'hDEAD80EF) begin n_fail++; $display("[TB] FAIL stall_rdata c%0d: got %h, required dead80ef", i, rsp_rdata); end
            if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_req_ready c%0d: got %b, required 0", i, req_ready); end
        end
        finish_rsp();
        do_txn(1'b0, LW, 32'h10, 32'h0, gr, ge, lat);
        n_checks++;
        if (gr !== 32'hDEAD80EF) begin n_fail++; $display("[TB] FAIL stall_no_write: got %h, required dead80ef", gr); end
    endtask

    task automatic test_misalign();
        logic [31:0] er, gr;
        logic        ee, ge;
        int          lat;
        do_txn(1'b0, LW, 32'h12, 32'h0, gr, ge, lat);
        n_checks += 2;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (ge !== 1'b1) begin n_fail++; $display("[TB] FAIL misalign_lw_err: got %b, required 1", ge); end
        if (gr !== 32'h0) begin n_fail++; $display("[TB] FAIL misalign_lw_rdata: got %h, required 0", gr); end
`else
        if (ge !== 1'b0) begin n_fail++; $display("[TB] FAIL misalign_lw_err: got %b, required 0", ge); end
        if (gr !== 32'hDEAD80EF) begin n_fail++; $display("[TB] FAIL misalign_lw_rdata: got %h, required dead80ef", gr); end
`endif
        model_txn(1'b0, LH, 32'h13, 32'h0, er, ee);
        do_txn(1'b0, LH, 32'h13, 32'h0, gr, ge, lat);
        n_checks += 2;
        if (ge !== ee) begin n_fail++; $display("[TB] FAIL misalign_lh_err: got %b, required %b", ge, ee); end
        if (gr !== er) begin n_fail++; $display("[TB] FAIL misalign_lh_rdata: got %h, required %h", gr, er); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] er, gr;
        logic        ee, ge;
        int          lat;
        do_txn(1'b0, LW, 32'h10, 32'h0, gr, ge, lat);
        start_req(1'b1, LW, 32'h20, 32'h12345678);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks += 4;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_rsp_valid: got %b, required 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL abort_rsp_rdata: got %h, required 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_rsp_err: got %b, required 0", rsp_err); end
        if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_req_ready: got %b, required 0", req_ready); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_release: req_ready=%b, required 1", req_ready); end
        model_txn(1'b0, LW, 32'h20, 32'h0, er, ee);
        do_txn(1'b0, LW, 32'h20, 32'h0, gr, ge, lat);
        n_checks++;
        if (gr !== er) begin n_fail++; $display("[TB] FAIL abort_no_store: got %h, required %h", gr, er); end
    endtask

    task automatic test_illegal_alias();
        logic [31:0] er, gr, d;
        logic        ee, ge;
        int          lat;
        do_txn(1'b0, 3'b011, 32'h10, 32'h0, gr, ge, lat);
        n_checks += 2;
        if (ge !== 1'b1) begin n_fail++; $display("[TB] FAIL f3_011_err: got %b, required 1", ge); end
        if (gr !== 32'h0) begin n_fail++; $display("[TB] FAIL f3_011_rdata: got %h, required 0", gr); end
        do_txn(1'b1, LBU, 32'h10, 32'h55, gr, ge, lat);
        n_checks++;
        if (ge !== 1'b1) begin n_fail++; $display("[TB] FAIL store_bu_err: got %b, required 1", ge); end
        do_txn(1'b0, LW, 32'h10, 32'h0, gr, ge, lat);
        n_checks++;
        if (gr !== 32'hDEAD80EF) begin n_fail++; $display("[TB] FAIL store_bu_no_write: got %h, required dead80ef", gr); end
        d = $urandom;
        model_txn(1'b1, LW, 32'h400, d, er, ee);
        do_txn(1'b1, LW, 32'h400, d, gr, ge, lat);
        do_txn(1'b0, LW, 32'h0, 32'h0, gr, ge, lat);
        n_checks++;
        if (gr !== d) begin n_fail++; $display("[TB] FAIL alias_0x400: got %h, required %h", gr, d); end
    endtask

    task automatic test_random();
        logic [31:0] er, gr, a, d;
        logic [2:0]  f3;
        logic        we, ee, ge;
        int          lat;
        for (int i = 0; i < 250; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            d  = $urandom;
            model_txn(we, f3, a, d, er, ee);
            do_txn(we, f3, a, d, gr, ge, lat);
            n_checks += 3;
            if (lat != LATENCY) begin n_fail++; $display("[TB] FAIL rand_latency #%0d: got %0d, required %0d", i, lat, LATENCY); end
            if (ge !== ee) begin n_fail++; $display("[TB] FAIL rand_err #%0d we=%b f3=%0d a=%h: got %b, required %b", i, we, f3, a, ge, ee); end
            if (gr !== er) begin n_fail++; $display("[TB] FAIL rand_rdata #%0d we=%b f3=%0d a=%h: got %h, required %h", i, we, f3, a, gr, er); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] er, a;
        logic [2:0]  f3;
        logic        ee;
        int          lat;
        start_req(1'b0, LW, 32'h10, 32'h0);
        wait_rsp(lat);
        for (int i = 0; i < 4; i++) begin
            f3 = (i % 2 == 0) ? LB : LW;
            a  = $urandom;
            model_txn(1'b0, f3, a, 32'h0, er, ee);
            rsp_ready  = 1'b1;
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_funct3 = f3;
            req_addr   = a;
            req_wdata  = 32'h0;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            n_checks += 2;
            if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_retired #%0d: rsp_valid=%b, required 0", i, rsp_valid); end
            if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_no_early_accept #%0d: req_ready=%b, required 1", i, req_ready); end
            @(posedge clk);
            #1 req_valid = 1'b0;
            wait_rsp(lat);
            n_checks += 2;
            if (lat != LATENCY) begin n_fail++; $display("[TB] FAIL b2b_latency #%0d: got %0d, required %0d", i, lat, LATENCY); end
            if (rsp_rdata !== er) begin n_fail++; $display("[TB] FAIL b2b_rdata #%0d: got %h, required %h", i, rsp_rdata, er); end
        end
        finish_rsp();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_word();
        test_byte();
        test_stall();
        test_misalign();
        test_reset_abort();
        test_illegal_alias();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
